// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master, slave and arbiter.
// Holds the arbiter state encoding and the default sizing constants, so
// every block on the bus agrees on them.
package bus_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int TIMEOUT_LEN = 6;
  localparam int DATA_WIDTH  = 8;
  localparam int ADDRS_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    BUSY  = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/serial_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Ports:
//   req      in  NUM_MASTERS  request vector
//   last     in  IW           index of the previous winner
//   vld      out 1            at least one request present
//   win_oh   out NUM_MASTERS  one-hot winner (zero when !vld)
//   win_idx  out IW           winner index
// The request vector is doubled and shifted right by last+1, so the first
// set bit of the low half is the next requester after last in circular order.
module rr_picker #(
  parameter  int NUM_MASTERS = 3,
  localparam int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last,
  output logic                   vld,
  output logic [NUM_MASTERS-1:0] win_oh,
  output logic [IW-1:0]          win_idx
);

  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  int                       start;
  int                       pick;

  always_comb begin
    start = (int'(last) + 1) % NUM_MASTERS;
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_MASTERS-1:0];
    vld   = |req;
    pick  = 0;
    // Descending scan so the lowest set bit (closest after last) wins.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) pick = i;
    end
    pick    = (start + pick) % NUM_MASTERS;
    win_idx = IW'(pick);
    win_oh  = vld ? (NUM_MASTERS'(1) << pick) : '0;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: shares the serial data bus between NUM_MASTERS masters.
// Registered one-hot grant, round-robin arbitration, ownership tracked through
// bus_util / slave_busy, with grant and hold watchdogs.
// Ports:
//   clk          in   system clock, rising edge
//   rstn         in   asynchronous active-low reset
//   m_request    in   per-master b_request (level)
//   bus_util     in   wired bus_util (owner driving the bus)
//   slave_busy   in   wired slave_busy (slave still completing)
//   m_grant      out  one-hot grant, registered
//   grant_id     out  index of current / last granted master
//   bus_free     out  high only in IDLE
//   timeout_err  out  1-cycle pulse on grant or hold timeout
module serial_bus_arbiter #(
  parameter  int NUM_MASTERS   = bus_pkg::NUM_MASTERS,
  parameter  int TIMEOUT_LEN   = bus_pkg::TIMEOUT_LEN,
  parameter  int HOLD_LIMIT_EN = 1,
  localparam int IW            = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_request,
  input  logic                   bus_util,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [IW-1:0]          grant_id,
  output logic                   bus_free,
  output logic                   timeout_err
);

  import bus_pkg::*;

  localparam logic [TIMEOUT_LEN-1:0] TMAX = '1;
  // Firing one count early makes the grant visible for exactly TMAX clocks.
  localparam logic [TIMEOUT_LEN-1:0] TFIRE = TMAX - 1'b1;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IW-1:0]          id_nxt;
  logic [IW-1:0]          rr_last, last_nxt;
  logic [TIMEOUT_LEN-1:0] tcnt, tcnt_nxt, tcnt_inc;
  logic                   err_nxt;
  logic                   watchdog;

  logic                   pick_vld;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IW-1:0]          pick_idx;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req     (m_request),
    .last    (rr_last),
    .vld     (pick_vld),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    grant_nxt = m_grant;
    id_nxt    = grant_id;
    last_nxt  = rr_last;
    tcnt_nxt  = tcnt;
    err_nxt   = 1'b0;
    tcnt_inc  = (tcnt == TMAX) ? tcnt : tcnt + 1'b1;
    watchdog  = (HOLD_LIMIT_EN != 0) && (tcnt == TFIRE);
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = pick_oh;
          id_nxt    = pick_idx;
          last_nxt  = pick_idx;
        end
      end
      GRANT: begin
        tcnt_nxt = tcnt_inc;
        if (bus_util) begin
          state_nxt = BUSY;
          tcnt_nxt  = '0;
        end else if (!m_request[grant_id]) begin
          state_nxt = GAP;
          grant_nxt = '0;
        end else if (tcnt == TFIRE) begin
          state_nxt = GAP;
          grant_nxt = '0;
          err_nxt   = 1'b1;
        end
      end
      BUSY: begin
        // Hold counter keeps running across BUSY/DRAIN round trips so the
        // limit bounds total ownership, not a single burst.
        tcnt_nxt = tcnt_inc;
        if (watchdog) begin
          state_nxt = GAP;
          grant_nxt = '0;
          err_nxt   = 1'b1;
        end else if (!bus_util) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        tcnt_nxt = tcnt_inc;
        if (watchdog) begin
          state_nxt = GAP;
          grant_nxt = '0;
          err_nxt   = 1'b1;
        end else if (bus_util) begin
          state_nxt = BUSY;
        end else if (!slave_busy) begin
          state_nxt = GAP;
          grant_nxt = '0;
        end
      end
      GAP: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      m_grant     <= '0;
      grant_id    <= '0;
      rr_last     <= IW'(NUM_MASTERS - 1);
      tcnt        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      m_grant     <= grant_nxt;
      grant_id    <= id_nxt;
      rr_last     <= last_nxt;
      tcnt        <= tcnt_nxt;
      timeout_err <= err_nxt;
    end
  end

  assign bus_free = (state == IDLE);

  // A master driving bus_util without a grant is a protocol violation.
  a_util_unowned: assert property (@(posedge clk) disable iff (!rstn)
    !(bus_util && (state == IDLE || state == GAP)));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(m_grant));
  a_err_pulse: assert property (@(posedge clk) disable iff (!rstn)
    timeout_err |=> !timeout_err);

endmodule

// File: tb/tb_serial_bus_arbiter.sv
module tb_serial_bus_arbiter;
  localparam int N     = 3;
  localparam int TL    = 6;
  localparam int LIMIT = (1 << TL) - 1;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] req = '0;
  logic         bu = 1'b0;
  logic         sb = 1'b0;
  logic [N-1:0] m_grant;
  logic [1:0]   grant_id;
  logic         bus_free;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_bus_arbiter #(.NUM_MASTERS(N), .TIMEOUT_LEN(TL), .HOLD_LIMIT_EN(1)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m_request   (req),
    .bus_util    (bu),
    .slave_busy  (sb),
    .m_grant     (m_grant),
    .grant_id    (grant_id),
    .bus_free    (bus_free),
    .timeout_err (timeout_err)
  );

  // Ownership model. mode: 0 free, 1 granted waiting for bus, 2 on bus,
  // 3 slave finishing, 4 dead cycle. age = clocks the current phase has run.
  typedef struct packed {
    int   mode;
    int   owner;
    int   last;
    int   age;
    logic err;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t step(mdl_t s, logic [N-1:0] r, logic u, logic b);
    mdl_t n;
    bit   found;
    n     = s;
    n.err = 1'b0;
    n.age = s.age + 1;
    found = 1'b0;
    case (s.mode)
      0: begin
        n.age = 0;
        if (r != 0) begin
          for (int k = 1; k <= N; k++) begin
            if (!found && r[(s.last + k) % N]) begin
              found   = 1'b1;
              n.owner = (s.last + k) % N;
            end
          end
          n.last = n.owner;
          n.mode = 1;
        end
      end
      1: begin
        if (u) begin n.mode = 2; n.age = 0; end
        else if (!r[s.owner]) n.mode = 4;
        else if (n.age == LIMIT) begin n.err = 1'b1; n.mode = 4; end
      end
      2: begin
        if (n.age == LIMIT) begin n.err = 1'b1; n.mode = 4; end
        else if (!u) n.mode = 3;
      end
      3: begin
        if (n.age == LIMIT) begin n.err = 1'b1; n.mode = 4; end
        else if (u) n.mode = 2;
        else if (!b) n.mode = 4;
      end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  function automatic logic [N-1:0] exp_grant(mdl_t s);
    if (s.mode >= 1 && s.mode <= 3) return N'(1) << s.owner;
    return '0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) mdl <= '{mode: 0, owner: 0, last: N - 1, age: 0, err: 1'b0};
    else       mdl <= step(mdl, req, bu, sb);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("grant",       32'(m_grant),     32'(exp_grant(mdl)));
    chk("grant_id",    32'(grant_id),    32'(mdl.owner));
    chk("bus_free",    32'(bus_free),    32'(mdl.mode == 0));
    chk("timeout_err", 32'(timeout_err), 32'(mdl.err));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (m_grant == '0 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_grant", 32'(m_grant != '0), 32'd1);
  endtask

  task automatic wait_release();
    int c;
    c = 0;
    while (m_grant != '0 && c < 12) begin
      @(negedge clk);
      c++;
    end
    chk("wait_release", 32'(m_grant == '0), 32'd1);
  endtask

  task automatic wait_err(output int cyc);
    cyc = 0;
    while (!timeout_err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int           cyc;
    logic [N-1:0] order [4];
    logic [N-1:0] exp_ord [4];
    exp_ord = '{3'b001, 3'b010, 3'b100, 3'b001};

    // 1: reset
    tick(3);
    chk("t1_rst_grant", 32'(m_grant), 32'd0);
    chk("t1_rst_free",  32'(bus_free), 32'd1);
    chk("t1_rst_err",   32'(timeout_err), 32'd0);
    rstn = 1'b1;
    tick(3);
    chk("t1_idle_free", 32'(bus_free), 32'd1);

    // 2: single request, long transfer, no slave wait
    req = 3'b010;
    tick(1);
    chk("t2_grant_lat", 32'(m_grant), 32'b010);
    chk("t2_grant_id",  32'(grant_id), 32'd1);
    bu = 1'b1;
    tick(20);
    bu = 1'b0; req = '0;
    tick(1);
    chk("t2_drain_hold", 32'(m_grant), 32'b010);
    tick(1);
    chk("t2_gap_grant", 32'(m_grant), 32'd0);
    chk("t2_gap_busy",  32'(bus_free), 32'd0);
    tick(1);
    chk("t2_free", 32'(bus_free), 32'd1);

    // 3: all requesting, rotation from a fresh reset
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(cyc);
      if (i > 0) chk("t3_dead_cycles", 32'(cyc), 32'd2);
      order[i] = m_grant;
      bu = 1'b1;
      tick(5);
      bu = 1'b0;
      wait_release();
    end
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), 32'(exp_ord[i]));

    // 4: grant timeout, then re-grant
    req = 3'b001;
    wait_grant(cyc);
    wait_err(cyc);
    chk("t4_timeout_cycles", 32'(cyc), 32'(LIMIT));
    chk("t4_timeout_grant",  32'(m_grant), 32'd0);
    tick(2);
    chk("t4_regrant", 32'(m_grant), 32'b001);
    req = '0;
    tick(2);

    // 5: slave_busy extends DRAIN; bus_util re-rise in DRAIN
    req = 3'b100;
    wait_grant(cyc);
    bu = 1'b1;
    tick(4);
    bu = 1'b0; sb = 1'b1; req = '0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("t5_drain_hold", 32'(m_grant), 32'b100);
    end
    sb = 1'b0;
    tick(1);
    chk("t5_release", 32'(m_grant), 32'd0);
    tick(1);
    req = 3'b100;
    wait_grant(cyc);
    bu = 1'b1;
    tick(2);
    bu = 1'b0;
    tick(1);
    bu = 1'b1;
    tick(1);
    chk("t5_rebusy_a", 32'(m_grant), 32'b100);
    tick(1);
    chk("t5_rebusy_b", 32'(m_grant), 32'b100);
    bu = 1'b0; req = '0;
    tick(2);
    chk("t5_rebusy_gap", 32'(m_grant), 32'd0);
    tick(1);

    // hold watchdog: bus_util never released
    req = 3'b001;
    wait_grant(cyc);
    chk("t_hold_owner", 32'(m_grant), 32'b001);
    bu = 1'b1;
    wait_err(cyc);
    bu = 1'b0; req = '0;
    chk("t_hold_cycles", 32'(cyc), 32'(LIMIT + 1));
    chk("t_hold_grant",  32'(m_grant), 32'd0);
    tick(2);

    // 6: asynchronous reset mid-BUSY
    req = 3'b100;
    wait_grant(cyc);
    chk("t6_owner", 32'(m_grant), 32'b100);
    bu = 1'b1;
    tick(3);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_grant", 32'(m_grant), 32'd0);
    chk("t6_async_free",  32'(bus_free), 32'd1);
    chk("t6_async_id",    32'(grant_id), 32'd0);
    bu = 1'b0; req = 3'b101;
    @(negedge clk);
    rstn = 1'b1;
    tick(1);
    chk("t6_first_winner", 32'(m_grant), 32'b001);
    req = '0;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
